// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, mux selects, control word, md states.
// PIPE_CTRL_EXCEPTION_EN enables setx/bex decode and md exception steering to r30.
package ctrl_pkg;

   localparam logic [4:0] OpRtype = 5'd0;
   localparam logic [4:0] OpJ     = 5'd1;
   localparam logic [4:0] OpBne   = 5'd2;
   localparam logic [4:0] OpJal   = 5'd3;
   localparam logic [4:0] OpJr    = 5'd4;
   localparam logic [4:0] OpAddi  = 5'd5;
   localparam logic [4:0] OpBlt   = 5'd6;
   localparam logic [4:0] OpSw    = 5'd7;
   localparam logic [4:0] OpLw    = 5'd8;
   localparam logic [4:0] OpSetx  = 5'd21;
   localparam logic [4:0] OpBex   = 5'd22;

   localparam logic [4:0] AluAdd = 5'd0;
   localparam logic [4:0] AluMul = 5'd6;
   localparam logic [4:0] AluDiv = 5'd7;

   localparam logic [1:0] PcNext   = 2'b00;
   localparam logic [1:0] PcBranch = 2'b01;
   localparam logic [1:0] PcTarget = 2'b10;
   localparam logic [1:0] PcRd     = 2'b11;

   localparam logic [1:0] DestRd      = 2'b00;
   localparam logic [1:0] DestRa      = 2'b01;
   localparam logic [1:0] DestRstatus = 2'b10;

   localparam logic [1:0] ValAlu  = 2'b00;
   localparam logic [1:0] ValDmem = 2'b01;
   localparam logic [1:0] ValPc   = 2'b10;

   localparam int unsigned RegRstatus = 30;

`ifdef PIPE_CTRL_EXCEPTION_EN
   localparam bit ExcEn = 1'b1;
`else
   localparam bit ExcEn = 1'b0;
`endif

   typedef struct packed {
      logic       rwe;
      logic       dmwe;
      logic       alu_sei;
      logic       bne;
      logic       blt;
      logic [4:0] aluop;
      logic [1:0] dest_sel;
      logic [1:0] val_sel;
      logic [1:0] pc_sel;
   } ctrl_t;

   typedef enum logic [1:0] {
      MdIdle = 2'd0,
      MdBusy = 2'd1,
      MdDone = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_seq.sv
// Mult/div sequencer: IDLE -> BUSY (MD_LATENCY cycles) -> DONE (one write pulse).
// With PIPE_CTRL_EXCEPTION_EN, an exception seen on the last BUSY cycle redirects the write to r30.
module md_seq
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              issue,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              md_exc,
   output logic              busy_cycle,
   output logic              md_busy,
   output logic              md_we,
   output logic [REG_AW-1:0] md_dest
);

   localparam int unsigned CntW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(MD_LATENCY - 1);

   md_state_e         state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              exc_q, exc_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      exc_d   = exc_q;
      unique case (state_q)
         MdIdle, MdDone: begin
            state_d = MdIdle;
            if (issue) begin
               state_d = MdBusy;
               cnt_d   = CntInit;
               rd_d    = issue_rd;
               exc_d   = 1'b0;
            end
         end
         MdBusy: begin
            if (cnt_q == '0) begin
               state_d = MdDone;
               exc_d   = md_exc;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = MdIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MdIdle;
         cnt_q   <= '0;
         rd_q    <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         exc_q   <= exc_d;
      end
   end

   assign busy_cycle = (state_q == MdBusy);
   assign md_busy    = (state_q != MdIdle);
   assign md_we      = (state_q == MdDone);
   assign md_dest    = !md_we ? '0 : ((ExcEn && exc_q) ? REG_AW'(RegRstatus) : rd_q);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decode + ID/EX control register with load-use and mult/div stall generation.
// PIPE_CTRL_EXCEPTION_EN adds setx/bex decode (see ctrl_pkg / md_seq).
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_aluop,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic              flush,
   input  logic              md_exc,
   output logic              stall,
   output logic              ex_valid,
   output logic              ex_rwe,
   output logic              ex_dmwe,
   output logic              ex_alu_sei,
   output logic              ex_bne,
   output logic              ex_blt,
   output logic [4:0]        ex_aluop,
   output logic [1:0]        ex_dest_sel,
   output logic [1:0]        ex_val_sel,
   output logic [1:0]        ex_pc_sel,
   output logic [REG_AW-1:0] ex_rd,
   output logic              md_start,
   output logic              md_busy,
   output logic              md_we,
   output logic [REG_AW-1:0] md_dest
);

   ctrl_t             dec, ex_q, ex_d;
   logic              is_md, use_rs, use_rt, use_rd;
   logic              ex_valid_q;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_is_lw, load_use, seq_busy_cycle, accept, issue;

   always_comb begin
      dec          = '0;
      dec.aluop    = AluAdd;
      dec.pc_sel   = PcNext;
      dec.dest_sel = DestRd;
      dec.val_sel  = ValAlu;
      is_md        = 1'b0;
      use_rs       = 1'b0;
      use_rt       = 1'b0;
      use_rd       = 1'b0;
      case (in_opcode)
         OpRtype: begin
            is_md     = (in_aluop == AluMul) || (in_aluop == AluDiv);
            dec.rwe   = !is_md;
            dec.aluop = in_aluop;
            use_rs    = 1'b1;
            use_rt    = 1'b1;
         end
         OpJ:  dec.pc_sel = PcTarget;
         OpJal: begin
            dec.rwe      = 1'b1;
            dec.dest_sel = DestRa;
            dec.val_sel  = ValPc;
            dec.pc_sel   = PcTarget;
         end
         OpJr: begin
            dec.pc_sel = PcRd;
            use_rd     = 1'b1;
         end
         OpBne, OpBlt: begin
            dec.bne    = (in_opcode == OpBne);
            dec.blt    = (in_opcode == OpBlt);
            dec.pc_sel = PcBranch;
            use_rs     = 1'b1;
            use_rd     = 1'b1;
         end
         OpAddi, OpLw: begin
            dec.rwe     = 1'b1;
            dec.alu_sei = 1'b1;
            dec.val_sel = (in_opcode == OpLw) ? ValDmem : ValAlu;
            use_rs      = 1'b1;
         end
         OpSw: begin
            dec.dmwe    = 1'b1;
            dec.alu_sei = 1'b1;
            use_rs      = 1'b1;
            use_rd      = 1'b1;
         end
`ifdef PIPE_CTRL_EXCEPTION_EN
         OpSetx: begin
            dec.rwe      = 1'b1;
            dec.dest_sel = DestRstatus;
         end
         OpBex: dec.pc_sel = PcTarget;
`endif
         default: ;
      endcase
   end

   // Only lw drives DMEM onto the writeback value mux, so val_sel identifies it in EX.
   assign ex_is_lw = ex_valid_q && (ex_q.val_sel == ValDmem) && (ex_rd_q != '0);
   assign load_use = in_valid && ex_is_lw &&
                     ((use_rs && in_rs == ex_rd_q) || (use_rt && in_rt == ex_rd_q) ||
                      (use_rd && in_rd == ex_rd_q));
   assign stall    = (load_use || (seq_busy_cycle && in_valid)) && !flush;
   assign accept   = in_valid && !stall && !flush;
   assign issue    = accept && is_md && reset_n;
   assign md_start = issue;

   assign ex_d    = accept ? dec : '0;
   assign ex_rd_d = accept ? in_rd : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_q       <= '0;
         ex_rd_q    <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         ex_q       <= ex_d;
         ex_rd_q    <= ex_rd_d;
         ex_valid_q <= accept;
      end
   end

   md_seq #(
      .REG_AW     (REG_AW),
      .MD_LATENCY (MD_LATENCY)
   ) u_md_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .issue      (issue),
      .issue_rd   (in_rd),
      .md_exc     (md_exc),
      .busy_cycle (seq_busy_cycle),
      .md_busy    (md_busy),
      .md_we      (md_we),
      .md_dest    (md_dest)
   );

   assign ex_valid    = ex_valid_q;
   assign ex_rwe      = ex_q.rwe;
   assign ex_dmwe     = ex_q.dmwe;
   assign ex_alu_sei  = ex_q.alu_sei;
   assign ex_bne      = ex_q.bne;
   assign ex_blt      = ex_q.blt;
   assign ex_aluop    = ex_q.aluop;
   assign ex_dest_sel = ex_q.dest_sel;
   assign ex_val_sel  = ex_q.val_sel;
   assign ex_pc_sel   = ex_q.pc_sel;
   assign ex_rd       = ex_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed literal checks plus random stimulus against a behavioural model.
module tb_pipe_ctrl_unit;

   localparam int Lat = 4;
`ifdef PIPE_CTRL_EXCEPTION_EN
   localparam bit TbExc = 1'b1;
`else
   localparam bit TbExc = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [4:0] in_opcode = '0, in_aluop = '0, in_rd = '0, in_rs = '0, in_rt = '0;
   logic       flush = 1'b0, md_exc = 1'b0;
   logic       stall, ex_valid, ex_rwe, ex_dmwe, ex_alu_sei, ex_bne, ex_blt;
   logic [4:0] ex_aluop, ex_rd, md_dest;
   logic [1:0] ex_dest_sel, ex_val_sel, ex_pc_sel;
   logic       md_start, md_busy, md_we;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   pipe_ctrl_unit #(
      .REG_AW     (5),
      .MD_LATENCY (Lat)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_opcode   (in_opcode),
      .in_aluop    (in_aluop),
      .in_rd       (in_rd),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .flush       (flush),
      .md_exc      (md_exc),
      .stall       (stall),
      .ex_valid    (ex_valid),
      .ex_rwe      (ex_rwe),
      .ex_dmwe     (ex_dmwe),
      .ex_alu_sei  (ex_alu_sei),
      .ex_bne      (ex_bne),
      .ex_blt      (ex_blt),
      .ex_aluop    (ex_aluop),
      .ex_dest_sel (ex_dest_sel),
      .ex_val_sel  (ex_val_sel),
      .ex_pc_sel   (ex_pc_sel),
      .ex_rd       (ex_rd),
      .md_start    (md_start),
      .md_busy     (md_busy),
      .md_we       (md_we),
      .md_dest     (md_dest)
   );

   typedef struct packed {
      bit       rwe, dmwe, sei, bne, blt, md, use_rs, use_rt, use_rd;
      bit [4:0] aluop;
      bit [1:0] dest, val, pc;
   } dec_t;

   // Control equations written directly from the instruction-set rules.
   function automatic dec_t spec_decode(input bit [4:0] op, input bit [4:0] alu);
      dec_t d;
      bit rt, j, bne, jal, jr, addi, blt, sw, lw, setx, bex;
      rt   = (op == 0);  j   = (op == 1);  bne = (op == 2); jal = (op == 3);
      jr   = (op == 4);  addi = (op == 5); blt = (op == 6); sw  = (op == 7);
      lw   = (op == 8);  setx = TbExc && (op == 21); bex = TbExc && (op == 22);
      d        = '0;
      d.md     = rt && (alu == 6 || alu == 7);
      d.rwe    = (rt && !d.md) || lw || jal || addi || setx;
      d.sei    = addi || lw || sw;
      d.dmwe   = sw;
      d.bne    = bne;
      d.blt    = blt;
      d.aluop  = rt ? alu : 5'd0;
      d.val    = {jal, lw};
      d.pc     = {j || jal || jr || bex, bne || blt || jr};
      d.dest   = setx ? 2'b10 : (jal ? 2'b01 : 2'b00);
      d.use_rs = rt || addi || lw || sw || bne || blt;
      d.use_rt = rt;
      d.use_rd = sw || bne || blt || jr;
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what sits in EX, and the mult/div job as a count of BUSY cycles left.
   bit       m_valid, m_done, m_exc;
   dec_t     m_ex;
   bit [4:0] m_rd, m_op, m_mrd;
   int       m_left;

   always @(negedge clock) begin : compare
      dec_t     d;
      bit       lu, st, acc, stt;
      bit [4:0] edest;
      if (!reset_n) begin
         m_valid = 0; m_ex = '0; m_rd = 0; m_op = 0;
         m_left = 0; m_done = 0; m_mrd = 0; m_exc = 0;
         d = '0; lu = 0; st = 0; acc = 0; stt = 0;
      end else begin
         d   = spec_decode(in_opcode, in_aluop);
         lu  = in_valid && m_valid && m_op == 8 && m_rd != 0 &&
               ((d.use_rs && in_rs == m_rd) || (d.use_rt && in_rt == m_rd) ||
                (d.use_rd && in_rd == m_rd));
         st  = (lu || (m_left > 0 && in_valid)) && !flush;
         acc = in_valid && !st && !flush;
         stt = acc && d.md;
      end
      edest = m_done ? ((TbExc && m_exc) ? 5'd30 : m_mrd) : 5'd0;
      chk("stall", stall, st);
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_rwe", ex_rwe, m_ex.rwe);
      chk("ex_dmwe", ex_dmwe, m_ex.dmwe);
      chk("ex_alu_sei", ex_alu_sei, m_ex.sei);
      chk("ex_bne", ex_bne, m_ex.bne);
      chk("ex_blt", ex_blt, m_ex.blt);
      chk("ex_aluop", ex_aluop, m_ex.aluop);
      chk("ex_dest_sel", ex_dest_sel, m_ex.dest);
      chk("ex_val_sel", ex_val_sel, m_ex.val);
      chk("ex_pc_sel", ex_pc_sel, m_ex.pc);
      chk("ex_rd", ex_rd, m_rd);
      chk("md_start", md_start, stt);
      chk("md_busy", md_busy, (m_left > 0) || m_done);
      chk("md_we", md_we, m_done);
      chk("md_dest", md_dest, edest);
      if (reset_n) begin
         m_done = 0;
         if (m_left > 0) begin
            if (m_left == 1) begin
               m_done = 1;
               m_exc  = md_exc;
            end
            m_left--;
         end
         if (stt) begin
            m_left = Lat;
            m_mrd  = in_rd;
            m_exc  = 0;
         end
         m_valid = acc;
         m_ex    = acc ? d : '0;
         m_rd    = acc ? in_rd : 5'd0;
         m_op    = acc ? in_opcode : 5'd0;
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input bit v, input int op, input int alu, input int rd, input int rs,
                      input int rt);
      in_valid  = v;
      in_opcode = 5'(op);
      in_aluop  = 5'(alu);
      in_rd     = 5'(rd);
      in_rs     = 5'(rs);
      in_rt     = 5'(rt);
   endtask

   int ops [15] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 21, 22, 9, 31};

   initial begin
      put(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      chk("reset_stall", stall, 0);
      chk("reset_ex_valid", ex_valid, 0);
      chk("reset_md_busy", md_busy, 0);
      chk("reset_pc_sel", ex_pc_sel, 0);
      reset_n = 1'b1;

      // Load-use: lw r5 then add r6,r5,r2
      cyc(); put(1, 8, 0, 5, 1, 0); #2 chk("lw_nostall", stall, 0);
      cyc(); put(1, 0, 0, 6, 5, 2); #2 chk("lu_stall", stall, 1);
      cyc(); #2 chk("lu_bubble", ex_valid, 0); chk("lu_once", stall, 0);
      cyc(); put(0, 0, 0, 0, 0, 0); #2 chk("lu_add_ex", ex_rd, 6); chk("lu_add_rwe", ex_rwe, 1);
      cyc(); put(1, 8, 0, 0, 1, 0);
      cyc(); put(1, 0, 0, 6, 0, 0); #2 chk("lw_r0_nostall", stall, 0);

      // mul r7 then add r8
      cyc(); put(1, 0, 6, 7, 1, 2); #2 chk("mul_start", md_start, 1);
      cyc(); put(1, 0, 0, 8, 1, 2); #2 chk("mul_ex_rwe", ex_rwe, 0); chk("mul_ex_valid", ex_valid, 1);
      chk("mul_stall1", stall, 1);
      repeat (3) begin cyc(); #2 chk("mul_stall", stall, 1); end
      cyc(); #2 chk("mul_we", md_we, 1); chk("mul_dest", md_dest, 7); chk("mul_done_nostall", stall, 0);
      cyc(); put(0, 0, 0, 0, 0, 0); #2 chk("mul_add_ex", ex_rd, 8); chk("mul_idle", md_busy, 0);

      // div r7 with exception on the last BUSY cycle
      cyc(); put(1, 0, 7, 7, 1, 2);
      cyc(); put(0, 0, 0, 0, 0, 0);
      cyc(); cyc(); cyc(); md_exc = 1'b1;
      cyc(); md_exc = 1'b0; #2 chk("div_we", md_we, 1); chk("div_dest", md_dest, TbExc ? 30 : 7);

      // Flush with jal, then flush during BUSY
      cyc(); put(1, 3, 0, 4, 0, 0); flush = 1'b1;
      cyc(); put(0, 0, 0, 0, 0, 0); flush = 1'b0; #2 chk("flush_valid", ex_valid, 0);
      chk("flush_pc_sel", ex_pc_sel, 0);
      cyc(); put(1, 0, 6, 9, 1, 2);
      cyc(); put(1, 0, 0, 3, 1, 2);
      cyc(); flush = 1'b1; #2 chk("flush_over_stall", stall, 0);
      cyc(); flush = 1'b0;
      cyc(); put(0, 0, 0, 0, 0, 0);
      cyc(); #2 chk("flush_md_we", md_we, 1); chk("flush_md_dest", md_dest, 9);

      // Branch/jump selects and sw
      cyc(); put(1, 2, 0, 1, 2, 0);
      cyc(); put(1, 6, 0, 1, 2, 0); #2 chk("bne_pc", ex_pc_sel, 1); chk("bne_val", ex_val_sel, 0);
      cyc(); put(1, 4, 0, 1, 0, 0); #2 chk("blt_pc", ex_pc_sel, 1); chk("blt_val", ex_val_sel, 0);
      cyc(); put(1, 3, 0, 1, 0, 0); #2 chk("jr_pc", ex_pc_sel, 3); chk("jr_val", ex_val_sel, 0);
      cyc(); put(1, 7, 3, 1, 2, 0); #2 chk("jal_pc", ex_pc_sel, 2); chk("jal_val", ex_val_sel, 2);
      cyc(); put(0, 0, 0, 0, 0, 0); #2 chk("sw_aluop", ex_aluop, 0); chk("sw_dmwe", ex_dmwe, 1);
      chk("sw_rwe", ex_rwe, 0);

      // Asynchronous reset in the middle of a BUSY sequence
      cyc(); put(1, 0, 6, 11, 1, 2);
      cyc(); put(1, 0, 0, 3, 1, 2);
      cyc(); #1 chk("pre_rst_busy", md_busy, 1); chk("pre_rst_stall", stall, 1);
      #1 reset_n = 1'b0;
      #1 chk("rst_busy", md_busy, 0); chk("rst_stall", stall, 0); chk("rst_ex_valid", ex_valid, 0);
      chk("rst_md_we", md_we, 0); chk("rst_md_start", md_start, 0);
      cyc(); put(0, 0, 0, 0, 0, 0);
      cyc(); reset_n = 1'b1;
      repeat (6) begin cyc(); #2 chk("rst_no_md_we", md_we, 0); end

      // Random traffic; the compare process checks every cycle
      repeat (1500) begin
         cyc();
         in_valid  = ($urandom_range(0, 9) != 0);
         in_opcode = 5'(ops[$urandom_range(0, 14)]);
         in_aluop  = (in_opcode == 5'd0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         in_rd     = 5'($urandom_range(0, 3));
         in_rs     = 5'($urandom_range(0, 3));
         in_rt     = 5'($urandom_range(0, 3));
         flush     = ($urandom_range(0, 9) == 0);
         md_exc    = ($urandom_range(0, 1) == 1);
      end
      cyc(); put(0, 0, 0, 0, 0, 0); flush = 1'b0; md_exc = 1'b0;
      repeat (8) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
